// File: rtl/uart_multi_tx.sv
// Multi-word UART transmitter: captures up to NUM_BYTES words per request and
// serialises a run-time selected number of them back-to-back on uart_tx.
module uart_multi_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int NUM_BYTES  = 3,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int BYTE_ORDER = 0,
  localparam int LEN_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           tx_req,
  input  logic [LEN_W-1:0]               tx_len,
  input  logic [NUM_BYTES*DATA_BITS-1:0] idats,
  output logic                           tx_busy,
  output logic                           byte_done,
  output logic                           tx_done,
  output logic                           uart_tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BAUD_W   = $clog2(BAUD_DIV);
  localparam int PAY_W    = NUM_BYTES * DATA_BITS;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [LEN_W:0]    NB_EXT    = (LEN_W + 1)'(NUM_BYTES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_cnt;
  logic [LEN_W-1:0]     word_cnt;
  logic [LEN_W-1:0]     len_eff;
  logic [PAY_W-1:0]     payload;

  logic [DATA_BITS-1:0] cur_word;
  logic [PAY_W-1:0]     payload_next;
  logic [LEN_W-1:0]     accept_len;
  logic [2:0]           nxt_bit;
  logic                 parity_bit;
  logic                 bit_tick;
  logic                 last_data;
  logic                 last_stop;
  logic                 last_word;

  // The word on the line is always at one end of the payload register;
  // finishing a word shifts the next one into that position.
  always_comb begin
    cur_word     = '0;
    payload_next = '0;
    if (BYTE_ORDER == 0) begin
      cur_word     = payload[DATA_BITS-1:0];
      payload_next = payload >> DATA_BITS;
    end else begin
      cur_word     = payload[PAY_W-1 -: DATA_BITS];
      payload_next = payload << DATA_BITS;
    end
  end

  always_comb begin
    accept_len = tx_len;
    if (tx_len == '0 || {1'b0, tx_len} > NB_EXT) accept_len = NB_EXT[LEN_W-1:0];
    parity_bit = (PARITY == 1) ? ~^cur_word : ^cur_word;
    nxt_bit    = bit_cnt + 3'd1;
    bit_tick   = (baud_cnt == BAUD_LAST);
    last_data  = (bit_cnt == DATA_LAST);
    last_stop  = (bit_cnt == STOP_LAST);
    last_word  = (word_cnt == len_eff - 1'b1);
  end

  assign tx_busy   = (state != S_IDLE);
  assign byte_done = (state == S_STOP) && last_stop && bit_tick;
  assign tx_done   = byte_done && last_word;

  // uart_tx is loaded with the value of the bit being entered, so the line
  // changes on the same edge as the state.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      len_eff  <= '0;
      payload  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      if (state != S_IDLE) baud_cnt <= bit_tick ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_req) begin
            payload  <= idats;
            len_eff  <= accept_len;
            word_cnt <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            state    <= S_START;
            uart_tx  <= 1'b0;
          end
        end
        S_START: begin
          if (bit_tick) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            uart_tx <= cur_word[0];
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (last_data) begin
              if (PARITY != 0) begin
                state   <= S_PAR;
                uart_tx <= parity_bit;
              end else begin
                state   <= S_STOP;
                bit_cnt <= '0;
                uart_tx <= 1'b1;
              end
            end else begin
              bit_cnt <= nxt_bit;
              uart_tx <= cur_word[nxt_bit];
            end
          end
        end
        S_PAR: begin
          if (bit_tick) begin
            state   <= S_STOP;
            bit_cnt <= '0;
            uart_tx <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (last_stop) begin
              if (last_word) begin
                state    <= S_IDLE;
                word_cnt <= '0;
                uart_tx  <= 1'b1;
              end else begin
                state    <= S_START;
                word_cnt <= word_cnt + 1'b1;
                payload  <= payload_next;
                uart_tx  <= 1'b0;
              end
            end else begin
              bit_cnt <= nxt_bit;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
